wide_operand_loader: RTL and testbench

//  Assembles two WIDTH-bit operands from a narrow CHUNK-bit valid/ready stream.

---
 rtl/wide_pkg.sv | 21 ++
 rtl/wide_operand_loader_if.sv | 23 ++
 rtl/wide_operand_loader_chunk_counter.sv | 38 +++
 rtl/wide_operand_loader.sv | 101 ++++++++++
 tb/tb_wide_operand_loader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wide_pkg.sv
// Shared definitions for the wide-datapath stages: loader state encoding
// and beat-count helpers.
package wide_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_X  = 2'd0,
    ST_LOAD_Y  = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // Beats needed to carry one width-bit operand in chunk-bit pieces.
  function automatic int unsigned nch(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_operand_loader_if.sv
// Stream-in / operand-pair-out bundle of the wide operand loader.
interface wide_operand_loader_if #(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned CHUNK = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [CHUNK-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, x_out, y_out
  );
endinterface

// File: rtl/wide_operand_loader_chunk_counter.sv
// Beat counter for the wide operand loader: counts 0..NCH-1 and wraps.
module wide_chunk_counter
  import wide_pkg::*;
#(
  parameter int unsigned NCH = 7,
  parameter int unsigned CW  = cnt_width(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(NCH - 1));

  // Next count: clear wins, otherwise step and wrap after the final beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wide_operand_loader.sv
// Wide operand loader: assembles x then y (WIDTH bits each) from a
// CHUNK-bit valid/ready stream, least-significant chunk first, and holds
// the pair until the consumer takes it.
// Optional feature: define WIDE_LOADER_ABORT_EN to add a synchronous abort
// input that returns to LOAD_X with the count cleared.
module wide_operand_loader
  import wide_pkg::*;
#(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned CHUNK = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef WIDE_LOADER_ABORT_EN
  input  logic abort,
`endif
  wide_operand_loader_if.slave bus
);

  localparam int unsigned NCH = nch(WIDTH, CHUNK);
  localparam int unsigned CW  = cnt_width(NCH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] ld_next;
  logic [CW-1:0]    cnt;
  logic             last, inc, clr, fire, abort_w;

`ifdef WIDE_LOADER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign bus.in_ready  = (state_q != ST_PRESENT) && !abort_w;
  assign bus.out_valid = (state_q == ST_PRESENT);
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign fire          = bus.in_valid && bus.in_ready;

  wide_chunk_counter #(.NCH(NCH), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .clr   (clr),
    .cnt   (cnt),
    .last  (last)
  );

  // Operand being loaded with the current beat merged in; walking the
  // WIDTH bits (not the padded chunk grid) drops last-chunk overflow bits.
  always_comb begin
    ld_next = (state_q == ST_LOAD_Y) ? y_q : x_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (32'(cnt) == i / CHUNK)
        ld_next[i] = bus.in_data[i % CHUNK];
    end
  end

  // Next state, operand updates and counter control; abort overrides all.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    inc     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_LOAD_X: if (fire) begin
        x_d = ld_next;
        inc = 1'b1;
        if (last) state_d = ST_LOAD_Y;
      end
      ST_LOAD_Y: if (fire) begin
        y_d = ld_next;
        inc = 1'b1;
        if (last) state_d = ST_PRESENT;
      end
      ST_PRESENT: if (bus.out_ready) state_d = ST_LOAD_X;
      default: state_d = ST_LOAD_X;
    endcase
    if (abort_w) begin
      state_d = ST_LOAD_X;
      clr     = 1'b1;
      inc     = 1'b0;
    end
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_X;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_wide_operand_loader.sv
// Randomised self-checking bench for wide_operand_loader (WIDTH=100, CHUNK=16).
module tb_wide_operand_loader;
  import wide_pkg::*;

  localparam int unsigned W  = 100;
  localparam int unsigned C  = 16;
  localparam int unsigned N  = 7;
  localparam int unsigned BW = N * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wide_operand_loader_if #(.WIDTH(W), .CHUNK(C)) bus ();
`ifdef WIDE_LOADER_ABORT_EN
  logic abort;
`endif

  wide_operand_loader #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef WIDE_LOADER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] cur_x = '0;
  logic [W-1:0] cur_y = '0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: operand after its first n chunks are replaced by beats,
  // keeping the value modulo 2**W.
  function automatic logic [W-1:0] assemble(input logic [BW-1:0] beats, input int unsigned n,
                                            input logic [W-1:0] prev);
    logic [BW-1:0] acc, m;
    acc = BW'(prev);
    m   = (BW'(1) << C) - BW'(1);
    for (int unsigned k = 0; k < n; k++)
      acc = (acc & ~(m << (k * C))) | (((beats >> (k * C)) & m) << (k * C));
    acc = acc & ((BW'(1) << W) - BW'(1));
    return acc[W-1:0];
  endfunction

  function automatic logic [BW-1:0] rand_beats();
    logic [BW-1:0] b;
    for (int unsigned k = 0; k < N; k++) b[k*C +: C] = C'($urandom);
    return b;
  endfunction

  // Offer n beats (x chunks then y chunks); gm 0=back-to-back, 1=alternate, 2=random gaps.
  task automatic feed(input logic [BW-1:0] xb, input logic [BW-1:0] yb,
                      input int unsigned n, input int unsigned gm);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic v;
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gm == 0)      v = 1'b1;
      else if (gm == 1) v = (cyc % 2) == 1;
      else              v = ($urandom_range(0, 1) == 1);
      bus.in_valid = v;
      if (idx < N) bus.in_data = xb[idx*C +: C];
      else         bus.in_data = yb[(idx-N)*C +: C];
      if (v && bus.in_ready) begin
        if (idx == 2*N-1) chk("early_valid", BW'(bus.out_valid), '0);
        idx++;
      end
    end
    if (idx < n) chk("feed_timeout", BW'(idx), BW'(n));
    @(negedge clk);
    bus.in_valid = 1'b0;
    cur_x = assemble(xb, (n < N) ? n : N, cur_x);
    if (n > N) cur_y = assemble(yb, n - N, cur_y);
  endtask

  task automatic check_pair(input string tag);
    chk({tag, "_valid"}, BW'(bus.out_valid), BW'(1));
    chk({tag, "_rdy"}, BW'(bus.in_ready), '0);
    chk({tag, "_x"}, BW'(bus.x_out), BW'(cur_x));
    chk({tag, "_y"}, BW'(bus.y_out), BW'(cur_y));
    chk({tag, "_add"}, BW'(bus.x_out) + BW'(bus.y_out), BW'(cur_x) + BW'(cur_y));
  endtask

  task automatic take(input string tag, input int unsigned delay);
    repeat (delay) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, BW'(bus.out_valid), '0);
    chk({tag, "_rdy_back"}, BW'(bus.in_ready), BW'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] xb, yb, one, two, ones;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef WIDE_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    one  = BW'(1);
    two  = BW'(2);
    ones = '1;

    // Reset state
    #1;
    chk("rst_x", BW'(bus.x_out), '0);
    chk("rst_y", BW'(bus.y_out), '0);
    chk("rst_valid", BW'(bus.out_valid), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", BW'(bus.in_ready), BW'(1));

    // Basic load 1 + 2
    feed(one, '0 | two, 2*N, 0);
    check_pair("load");
    chk("load_add3", BW'(bus.x_out) + BW'(bus.y_out), BW'(3));
    take("load", 0);

    // Truncation of last chunk
    feed(ones, '0, 2*N, 0);
    check_pair("trunc");
    chk("trunc_x_all1", BW'(bus.x_out), (BW'(1) << W) - BW'(1));
    take("trunc", 1);

    // Backpressure: pair held, offered beats ignored
    xb = rand_beats();
    yb = rand_beats();
    feed(xb, yb, 2*N, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = C'($urandom);
      chk("bp_rdy", BW'(bus.in_ready), '0);
      chk("bp_valid", BW'(bus.out_valid), BW'(1));
      chk("bp_x", BW'(bus.x_out), BW'(cur_x));
      chk("bp_y", BW'(bus.y_out), BW'(cur_y));
    end
    bus.in_valid = 1'b0;
    take("bp", 0);

    // Gaps give identical result
    feed(one, two, 2*N, 1);
    check_pair("gap");
    chk("gap_add3", BW'(bus.x_out) + BW'(bus.y_out), BW'(3));
    take("gap", 0);

    // Mid-load reset after 3 x beats
    xb = rand_beats();
    feed(xb, '0, 3, 0);
    chk("part_x", BW'(bus.x_out), BW'(cur_x));
    rst_n = 1'b0;
    #1;
    cur_x = '0;
    cur_y = '0;
    chk("mrst_x", BW'(bus.x_out), '0);
    chk("mrst_y", BW'(bus.y_out), '0);
    chk("mrst_valid", BW'(bus.out_valid), '0);
    chk("mrst_cnt", BW'(dut.cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    xb = rand_beats();
    yb = rand_beats();
    feed(xb, yb, 2*N, 2);
    check_pair("mrst_clean");
    take("mrst_clean", 0);

`ifdef WIDE_LOADER_ABORT_EN
    // Abort mid-load: offered beat not consumed, operands kept, count cleared
    xb = rand_beats();
    feed(xb, '0, 3, 0);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = C'($urandom);
    #1;
    chk("abort_rdy", BW'(bus.in_ready), '0);
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_x", BW'(bus.x_out), BW'(cur_x));
    chk("abort_valid", BW'(bus.out_valid), '0);
    chk("abort_cnt", BW'(dut.cnt), '0);
    xb = rand_beats();
    yb = rand_beats();
    feed(xb, yb, 2*N, 2);
    check_pair("abort_clean");
    take("abort_clean", 0);
`endif

    // Random pairs with random gaps and consumer delays
    for (int t = 0; t < 8; t++) begin
      xb = rand_beats();
      yb = rand_beats();
      feed(xb, yb, 2*N, 2);
      check_pair("rnd");
      take("rnd", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
